// File: rtl/arb_pkg.sv
// arb_pkg: shared types and defaults for the arbiter requester agent
package arb_pkg;

   localparam int LEN_W_DEF        = 4;
   localparam int TAG_W_DEF        = 4;
   localparam int STARVE_LIMIT_DEF = 64;

   typedef enum logic [1:0] {IDLE, REQ, BURST, RELEASE} arb_req_state_t;

   typedef struct packed {
      logic [LEN_W_DEF-1:0] len;
      logic [TAG_W_DEF-1:0] tag;
   } arb_desc_t;

endpackage

// File: rtl/arb_requester_if.sv
// arb_requester_if: descriptor, arbiter and beat signals of one requester port
interface arb_requester_if
   import arb_pkg::*;
#(
   parameter int LEN_W = LEN_W_DEF,
   parameter int TAG_W = TAG_W_DEF
);

   logic             i_desc_valid;
   logic             o_desc_ready;
   logic [LEN_W-1:0] i_desc_len;
   logic [TAG_W-1:0] i_desc_tag;
   logic             o_req;
   logic             i_grant;
   logic             o_beat_valid;
   logic [TAG_W-1:0] o_beat_tag;
   logic [LEN_W-1:0] o_beat_idx;
   logic             o_beat_last;
   logic             o_busy;
   logic             o_starved;

   modport slave (
      input  i_desc_valid, i_desc_len, i_desc_tag, i_grant,
      output o_desc_ready, o_req, o_beat_valid, o_beat_tag, o_beat_idx,
             o_beat_last, o_busy, o_starved
   );

   modport master (
      output i_desc_valid, i_desc_len, i_desc_tag, i_grant,
      input  o_desc_ready, o_req, o_beat_valid, o_beat_tag, o_beat_idx,
             o_beat_last, o_busy, o_starved
   );

endinterface

// File: rtl/arb_desc_fifo.sv
// arb_desc_fifo: small synchronous descriptor FIFO with combinational head
module arb_desc_fifo
   import arb_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = arb_desc_t
) (
   input  logic i_clk,
   input  logic i_rstn,
   input  logic i_push,
   input  T     i_data,
   input  logic i_pop,
   output T     o_head,
   output logic o_full,
   output logic o_empty
);

   localparam int AW = $clog2(DEPTH);

   T             mem_q [DEPTH];
   logic [AW:0]  wr_q, rd_q;
   logic         push, pop;

   assign o_empty = wr_q == rd_q;
   assign o_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign o_head  = mem_q[rd_q[AW-1:0]];
   assign push    = i_push && !o_full;
   assign pop     = i_pop && !o_empty;

   // pointers carry an extra wrap bit so full and empty are distinguishable
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         wr_q <= '0;
         rd_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (push) mem_q[wr_q[AW-1:0]] <= i_data;
         if (push) wr_q <= wr_q + (AW+1)'(1);
         if (pop)  rd_q <= rd_q + (AW+1)'(1);
      end
   end

endmodule

// File: rtl/arb_requester.sv
// arb_requester: queues descriptors and bursts them through a req/grant arbiter,
// releasing req for one cycle per descriptor; ARB_REQUESTER_STARVE_MON_EN adds a starvation flag
module arb_requester
   import arb_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int LEN_W        = LEN_W_DEF,
   parameter int TAG_W        = TAG_W_DEF,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic            i_clk,
   input  logic            i_rstn,
   arb_requester_if.slave  bus
);

   typedef struct packed {
      logic [LEN_W-1:0] len;
      logic [TAG_W-1:0] tag;
   } desc_t;

   arb_req_state_t   state_q, state_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   desc_t            in_desc, head;
   logic             full, empty, active, beat, last;

   assign in_desc = '{len: bus.i_desc_len, tag: bus.i_desc_tag};

   arb_desc_fifo #(.DEPTH(DEPTH), .T(desc_t)) u_fifo (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_push  (bus.i_desc_valid),
      .i_data  (in_desc),
      .i_pop   (last),
      .o_head  (head),
      .o_full  (full),
      .o_empty (empty)
   );

   // next state and beat counter; the head is popped on its last beat
   always_comb begin
      active  = state_q == REQ || state_q == BURST;
      beat    = active && bus.i_grant;
      last    = beat && cnt_q == head.len;
      cnt_d   = last ? '0 : beat ? cnt_q + LEN_W'(1) : cnt_q;
      state_d = active ? (last ? RELEASE : beat ? BURST : state_q)
                       : (empty ? IDLE : REQ);
   end

   // state and beat counter registers
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.o_desc_ready = !full;
   assign bus.o_req        = active;
   assign bus.o_beat_valid = beat;
   assign bus.o_beat_tag   = head.tag;
   assign bus.o_beat_idx   = cnt_q;
   assign bus.o_beat_last  = last;
   assign bus.o_busy       = !empty || state_q != IDLE;

`ifdef ARB_REQUESTER_STARVE_MON_EN
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic [SW-1:0] wait_q, wait_d;

   // count ungranted request cycles, saturating, cleared by any beat
   always_comb
      wait_d = beat ? '0
             : (active && !bus.i_grant && wait_q != SW'(STARVE_LIMIT)) ? wait_q + SW'(1)
             : wait_q;

   // wait counter register
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) wait_q <= '0;
      else         wait_q <= wait_d;
   end

   assign bus.o_starved = wait_q == SW'(STARVE_LIMIT);
`else
   assign bus.o_starved = 1'b0 && (STARVE_LIMIT == 0);
`endif

endmodule
